// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32IC instruction-fetch slice.
package fetch_pkg;

  typedef logic [15:0] halfword_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A halfword starts a compressed instruction unless its two low bits are 2'b11.
  function automatic logic is_rvc(halfword_t h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Circular halfword FIFO: push 0/1/2, pop 0/1/2, flush, with head and head+1 read ports.
module fetch_hw_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [1:0]                 push_n,
  input  logic [15:0]                push_lo,
  input  logic [15:0]                push_hi,
  input  logic [1:0]                 pop_n,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                head0,
  output logic [15:0]                head1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  halfword_t     mem_q [DEPTH];
  halfword_t     mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_n != 2'd0) mem_d[wr_ptr_q] = push_lo;
      if (push_n == 2'd2) mem_d[wr_ptr_q + PW'(1)] = push_hi;
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head0 = mem_q[rd_ptr_q];
  assign head1 = mem_q[rd_ptr_q + PW'(1)];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));

endmodule

// File: rtl/ifetch_cbuf.sv
// RV32IC fetch unit: word fetch from a 1-cycle imem into a halfword queue, C/32-bit extraction, redirect.
// Decode handshake: an instruction transfers in a cycle where id_valid && id_ready (ignored during redirect).
module ifetch_cbuf
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 9,
  parameter int          HW_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic               id_is_c
);

  localparam int          CW         = $clog2(HW_DEPTH) + 1;
  localparam logic [31:0] RESET_PC_H = {RESET_PC[31:1], 1'b0};
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(HW_DEPTH - 2);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_first_q, drop_first_d;

  logic [CW-1:0] count;
  logic [15:0]   head0, head1;
  logic [1:0]    push_n, pop_n;
  logic [15:0]   push_lo, push_hi;
  logic [CW:0]   credit;
  logic [29:0]   issue_word;
  logic          head_is_c;
  logic          unused_bits;

  assign unused_bits = ^{redirect_pc[0], fetch_pc_q[1:0]};

  fetch_hw_queue #(.DEPTH(HW_DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push_n  (push_n),
    .push_lo (push_lo),
    .push_hi (push_hi),
    .pop_n   (pop_n),
    .count   (count),
    .head0   (head0),
    .head1   (head1)
  );

  // Credit ignores a same-cycle pop so the queue can never overflow.
  always_comb begin
    credit     = {1'b0, count} + {{(CW-1){1'b0}}, inflight_q, 1'b0};
    imem_req   = !reset && (redirect_valid || credit <= CREDIT_MAX);
    issue_word = redirect_valid ? redirect_pc[31:2] : fetch_pc_q[31:2];
    imem_addr  = issue_word[IMEM_AW-1:0];
  end

  always_comb begin
    head_is_c = is_rvc(head0);
    id_valid  = head_is_c ? (count != '0) : (count >= CW'(2));
    id_is_c   = head_is_c && (count != '0);
    id_pc     = head_pc_q;
    id_instr  = '0;
    if (id_valid) id_instr = head_is_c ? {16'h0000, head0} : {head1, head0};
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    head_pc_d    = head_pc_q;
    drop_first_d = drop_first_q;
    inflight_d   = imem_req;
    push_n       = 2'd0;
    push_lo      = imem_rdata[15:0];
    push_hi      = imem_rdata[31:16];
    pop_n        = 2'd0;
    if (imem_req) fetch_pc_d = {issue_word, 2'b00} + 32'd4;
    if (redirect_valid) begin
      head_pc_d    = {redirect_pc[31:1], 1'b0};
      drop_first_d = redirect_pc[1];
    end else begin
      if (inflight_q) begin
        if (drop_first_q) begin
          // Target sits in the upper half of the first word: skip the lower half.
          push_n       = 2'd1;
          push_lo      = imem_rdata[31:16];
          drop_first_d = 1'b0;
        end else begin
          push_n = 2'd2;
        end
      end
      if (id_valid && id_ready) begin
        pop_n     = head_is_c ? 2'd1 : 2'd2;
        head_pc_d = head_pc_q + (head_is_c ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC_H;
      head_pc_q    <= RESET_PC_H;
      inflight_q   <= 1'b0;
      drop_first_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      head_pc_q    <= head_pc_d;
      inflight_q   <= inflight_d;
      drop_first_q <= drop_first_d;
    end
  end

endmodule

// File: tb/tb_ifetch_cbuf.sv
// Bench for ifetch_cbuf: architectural instruction-stream model plus directed literal checks.
module tb_ifetch_cbuf;
  import fetch_pkg::*;

  localparam int          AW  = 9;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          id_is_c;

  logic [31:0] mem [1<<AW];
  logic [64:0] exp_q [$];
  logic [31:0] gen_pc;
  int          n_chk = 0;
  int          n_fail = 0;
  int          wd = 0;

  ifetch_cbuf #(.RESET_PC(RPC), .IMEM_AW(AW), .HW_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_is_c        (id_is_c)
  );

  // Clock and synchronous 1-cycle-latency instruction memory.
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[AW+1:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Next architectural instruction from gen_pc, packed as {pc, instr, is_c}.
  task automatic push_exp();
    logic [15:0] lo, hi;
    lo = hw_at(gen_pc);
    hi = hw_at(gen_pc + 32'd2);
    if (lo[1:0] != 2'b11) begin
      exp_q.push_back({gen_pc, 16'h0000, lo, 1'b1});
      gen_pc = gen_pc + 32'd2;
    end else begin
      exp_q.push_back({gen_pc, hi, lo, 1'b0});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // Scoreboard: checks every cycle, 2 time units after the inputs change.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1) begin
      n_chk++;
      if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_pc !== RPC || id_instr !== 32'h0 || id_is_c !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%b req=%b pc=%h instr=%h c=%b, expected 0 0 %h 0 0",
                 id_valid, imem_req, id_pc, id_instr, id_is_c, RPC);
      end
      exp_q.delete();
      gen_pc = RPC;
      wd = 0;
    end else begin
      if (exp_q.size() == 0) push_exp();
      n_chk++;
      if (id_valid === 1'b1) begin
        if ({id_pc, id_instr, id_is_c} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stream: got pc=%h instr=%h c=%b, expected pc=%h instr=%h c=%b",
                   id_pc, id_instr, id_is_c, exp_q[0][64:33], exp_q[0][32:1], exp_q[0][0]);
        end
      end else if (id_instr !== 32'h0 || id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_instr: got valid=%b instr=%h, expected valid=0 instr=0", id_valid, id_instr);
      end
      if (redirect_valid) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== redirect_pc[AW+1:2]) begin
          n_fail++;
          $display("FAIL redirect_issue: got req=%b addr=%h, expected req=1 addr=%h",
                   imem_req, imem_addr, redirect_pc[AW+1:2]);
        end
        exp_q.delete();
        gen_pc = {redirect_pc[31:1], 1'b0};
        wd = 0;
      end else if (id_valid === 1'b1 && id_ready) begin
        void'(exp_q.pop_front());
        wd = 0;
      end else if (!id_ready) begin
        wd = 0;
      end else begin
        wd++;
        n_chk++;
        if (wd > 12) begin
          n_fail++;
          $display("FAIL progress: got %0d idle ready cycles, expected at most 12", wd);
          wd = 0;
        end
      end
    end
  end

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
    @(negedge clk);
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, ex);
    end
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 3) == 0) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11)      h[1:0] = 2'b01;
    return h;
  endfunction

  initial begin
    reset = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = {rand_hw(), rand_hw()};

    // Aligned 32-bit instructions from reset.
    cyc(1, 0, 0, 1);
    mem[0] = 32'h00a00093; mem[1] = 32'h00400113; mem[2] = 32'h00208193;
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("c0_req", {31'b0, imem_req}, 32'd1);
    chk("c0_addr", {23'b0, imem_addr}, 32'd0);
    chk("c0_valid", {31'b0, id_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("c1_valid", {31'b0, id_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("c2_valid", {31'b0, id_valid}, 32'd1);
    chk("c2_pc", id_pc, 32'h0);
    chk("c2_instr", id_instr, 32'h00a00093);
    chk("c2_is_c", {31'b0, id_is_c}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("c3_pc", id_pc, 32'h4);
    chk("c3_instr", id_instr, 32'h00400113);

    // Backpressure: fetch must stop once the queue credit is used up.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      if (i >= 4) begin
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_valid", {31'b0, id_valid}, 32'd1);
      end
    end
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);

    // Two C instructions in word 0, then redirect into the upper half of word 0x40.
    cyc(1, 0, 0, 1);
    mem[0] = {16'h0505, 16'h4501};
    mem[32'h40] = {16'h4505, 16'h1234};
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rvc0_pc", id_pc, 32'h0);
    chk("rvc0_instr", id_instr, 32'h00004501);
    chk("rvc0_is_c", {31'b0, id_is_c}, 32'd1);
    cyc(1, 0, 0, 0);
    chk("rvc1_pc", id_pc, 32'h2);
    chk("rvc1_instr", id_instr, 32'h00000505);
    chk("rvc1_is_c", {31'b0, id_is_c}, 32'd1);
    cyc(1, 1, 32'h0000_0102, 0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", {23'b0, imem_addr}, 32'h040);
    cyc(1, 0, 0, 0);
    chk("redir_t1_valid", {31'b0, id_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("redir_t2_valid", {31'b0, id_valid}, 32'd1);
    chk("redir_t2_pc", id_pc, 32'h102);
    chk("redir_t2_instr", id_instr, 32'h00004505);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);

    // 32-bit instruction straddling words 0 and 1.
    cyc(1, 0, 0, 1);
    mem[0] = {16'h0093, 16'h4501};
    mem[1] = {16'h4501, 16'h00a0};
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("strad0_instr", id_instr, 32'h00004501);
    cyc(1, 0, 0, 0);
    chk("strad1_pc", id_pc, 32'h2);
    chk("strad1_instr", id_instr, 32'h00a00093);
    chk("strad1_is_c", {31'b0, id_is_c}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);

    // One-cycle reset mid-stream.
    cyc(1, 0, 0, 1);
    chk("midrst_valid", {31'b0, id_valid}, 32'd0);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("midrst_c0_addr", {23'b0, imem_addr}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("midrst_c1_valid", {31'b0, id_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("midrst_c2_valid", {31'b0, id_valid}, 32'd1);
    chk("midrst_c2_pc", id_pc, 32'h0);
    chk("midrst_c2_instr", id_instr, 32'h00004501);

    // Random traffic: ready jitter, redirects anywhere in imem, occasional reset.
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc($urandom_range(0, 3) != 0, r < 3, {21'h0, 11'($urandom)}, r == 99);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
